// File: rtl/lookup_scan_table_if.sv
// Write/clear/lookup bus of the scan table; the master is the lookup controller.
interface lookup_scan_table_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             clr_en;
  logic [IDXW-1:0]  clr_idx;
  logic             lk_start;
  logic [WIDTH-1:0] lk_key;
  logic             lk_busy;
  logic             lk_done;
  logic             lk_hit;
  logic [IDXW-1:0]  lk_min_idx;
  logic [IDXW-1:0]  lk_max_idx;
  logic [CNTW-1:0]  lk_count;
  logic             any_valid;

  modport master (
    output wr_en, wr_idx, wr_data, clr_en, clr_idx, lk_start, lk_key,
    input  lk_busy, lk_done, lk_hit, lk_min_idx, lk_max_idx, lk_count, any_valid
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, clr_en, clr_idx, lk_start, lk_key,
    output lk_busy, lk_done, lk_hit, lk_min_idx, lk_max_idx, lk_count, any_valid
  );
endinterface

// File: rtl/lookup_scan_table.sv
// DEPTH x WIDTH value table with valid bits; a key lookup scans one entry per cycle.
// Latency: lk_done in the cycle after DEPTH edges past the accepted start; starts during a scan are dropped.
module lookup_scan_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               init,
  lookup_scan_table_if.slave bus
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] key_q;
  logic [IDXW-1:0]  ptr;
  logic             acc_hit;
  logic [IDXW-1:0]  acc_min;
  logic [IDXW-1:0]  acc_max;
  logic [CNTW-1:0]  acc_cnt;

  logic             match;
  logic             hit_n;
  logic [IDXW-1:0]  min_n;
  logic [IDXW-1:0]  max_n;
  logic [CNTW-1:0]  cnt_n;

  // Clear is applied after the write so it wins on a shared index.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      if (bus.wr_en) begin
        data_q[bus.wr_idx] <= bus.wr_data;
        vld_q[bus.wr_idx]  <= 1'b1;
      end
      if (bus.clr_en) vld_q[bus.clr_idx] <= 1'b0;
    end
  end

  assign bus.any_valid = |vld_q;

  // Compares the registered entry, so a same-cycle write to ptr is not seen.
  assign match = vld_q[ptr] && (data_q[ptr] == key_q);
  assign hit_n = acc_hit | match;
  assign min_n = (match && !acc_hit) ? ptr : acc_min;
  assign max_n = match ? ptr : acc_max;
  assign cnt_n = acc_cnt + CNTW'(match);

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state          <= IDLE;
      key_q          <= '0;
      ptr            <= '0;
      acc_hit        <= 1'b0;
      acc_min        <= '0;
      acc_max        <= '0;
      acc_cnt        <= '0;
      bus.lk_busy    <= 1'b0;
      bus.lk_done    <= 1'b0;
      bus.lk_hit     <= 1'b0;
      bus.lk_min_idx <= '0;
      bus.lk_max_idx <= '0;
      bus.lk_count   <= '0;
    end else begin
      bus.lk_done <= 1'b0;
      case (state)
        SCAN: begin
          acc_hit <= hit_n;
          acc_min <= min_n;
          acc_max <= max_n;
          acc_cnt <= cnt_n;
          ptr     <= ptr + 1'b1;
          if (ptr == IDXW'(DEPTH - 1)) begin
            ptr            <= '0;
            state          <= DONE;
            bus.lk_busy    <= 1'b0;
            bus.lk_done    <= 1'b1;
            bus.lk_hit     <= hit_n;
            bus.lk_min_idx <= min_n;
            bus.lk_max_idx <= max_n;
            bus.lk_count   <= cnt_n;
          end
        end
        default: begin
          if (bus.lk_start) begin
            state       <= SCAN;
            key_q       <= bus.lk_key;
            ptr         <= '0;
            acc_hit     <= 1'b0;
            acc_min     <= '0;
            acc_max     <= '0;
            acc_cnt     <= '0;
            bus.lk_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lookup_scan_table.sv
// Scoreboard bench for lookup_scan_table: expected results queued at start, checked on lk_done.
module tb_lookup_scan_table;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic clk  = 1'b0;
  logic init = 1'b1;
  always #5 clk = ~clk;

  lookup_scan_table_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

  lookup_scan_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .init (init),
    .bus  (ifc)
  );

  typedef struct {
    logic       hit;
    logic [2:0] mn;
    logic [2:0] mx;
    logic [3:0] cnt;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!init && ifc.lk_done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stray_done: lk_done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        if ({ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count} !== {e.hit, e.mn, e.mx, e.cnt}) begin
          bad++;
          $display("FAIL result: hit/min/max/cnt got %b/%0d/%0d/%0d required %b/%0d/%0d/%0d",
                   ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count, e.hit, e.mn, e.mx, e.cnt);
        end
        total++;
        if (cyc !== e.at) begin
          bad++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [3:0] d);
    ifc.wr_en = 1'b1; ifc.wr_idx = 3'(idx); ifc.wr_data = d;
    tick(1);
    ifc.wr_en = 1'b0;
  endtask

  task automatic clr(input int idx);
    ifc.clr_en = 1'b1; ifc.clr_idx = 3'(idx);
    tick(1);
    ifc.clr_en = 1'b0;
  endtask

  task automatic push_exp(input logic h, input int mn, input int mx, input int cnt, input int at);
    exp_t x;
    x.hit = h; x.mn = 3'(mn); x.mx = 3'(mx); x.cnt = 4'(cnt); x.at = at;
    sb.push_back(x);
  endtask

  task automatic start_lookup(input logic [3:0] key, input logic h, input int mn, input int mx, input int cnt);
    ifc.lk_start = 1'b1; ifc.lk_key = key;
    push_exp(h, mn, mx, cnt, cyc + 9);
    tick(1);
    ifc.lk_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_any(input string name, input logic req);
    total++;
    if (ifc.any_valid !== req) begin
      bad++;
      $display("FAIL %s: any_valid got %b required %b", name, ifc.any_valid, req);
    end
  endtask

  task automatic test_reset();
    tick(2);
    total++;
    if ({ifc.lk_busy, ifc.lk_done, ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count, ifc.any_valid} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {ifc.lk_busy, ifc.lk_done, ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count, ifc.any_valid});
    end
    init = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    wr(1, 4'h5); wr(3, 4'h5); wr(6, 4'h5);
    check_any("basic_any", 1'b1);
    start_lookup(4'h5, 1'b1, 1, 6, 3);
    total++;
    if (ifc.lk_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: lk_busy got %b required 1", ifc.lk_busy);
    end
    wait_drain();
  endtask

  task automatic test_clear();
    clr(3);
    start_lookup(4'h5, 1'b1, 1, 6, 2);
    wait_drain();
    start_lookup(4'hA, 1'b0, 0, 0, 0);
    wait_drain();
  endtask

  task automatic test_wr_clr();
    clr(1); clr(6);
    check_any("wrclr_empty", 1'b0);
    ifc.wr_en = 1'b1; ifc.wr_idx = 3'd2; ifc.wr_data = 4'h7;
    ifc.clr_en = 1'b1; ifc.clr_idx = 3'd2;
    tick(1);
    ifc.wr_en = 1'b0; ifc.clr_en = 1'b0;
    check_any("wrclr_same_idx", 1'b0);
    start_lookup(4'h7, 1'b0, 0, 0, 0);
    wait_drain();
    wr(2, 4'h7);
    check_any("wrclr_written", 1'b1);
    ifc.wr_en = 1'b1; ifc.wr_idx = 3'd4; ifc.wr_data = 4'h7;
    ifc.clr_en = 1'b1; ifc.clr_idx = 3'd2;
    tick(1);
    ifc.wr_en = 1'b0; ifc.clr_en = 1'b0;
    start_lookup(4'h7, 1'b1, 4, 4, 1);
    wait_drain();
  endtask

  task automatic test_midscan();
    wr(1, 4'h5);
    ifc.lk_start = 1'b1; ifc.lk_key = 4'h5;
    push_exp(1'b1, 1, 7, 2, cyc + 9);
    tick(1);
    ifc.lk_start = 1'b0;
    tick(2);
    ifc.lk_start = 1'b1; ifc.lk_key = 4'h7;
    tick(1);
    ifc.lk_start = 1'b0;
    tick(1);
    ifc.wr_en = 1'b1; ifc.wr_idx = 3'd0; ifc.wr_data = 4'h5;
    tick(1);
    ifc.wr_idx = 3'd7;
    tick(1);
    ifc.wr_en = 1'b0;
    wait_drain();
    start_lookup(4'h5, 1'b1, 0, 7, 3);
    wait_drain();
  endtask

  task automatic test_reset_midscan();
    ifc.lk_start = 1'b1; ifc.lk_key = 4'h5;
    tick(1);
    ifc.lk_start = 1'b0;
    tick(2);
    init = 1'b1;
    #1;
    total++;
    if ({ifc.lk_busy, ifc.lk_done, ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count, ifc.any_valid} !== 15'd0) begin
      bad++;
      $display("FAIL midscan_reset: got %b required all zero",
               {ifc.lk_busy, ifc.lk_done, ifc.lk_hit, ifc.lk_min_idx, ifc.lk_max_idx, ifc.lk_count, ifc.any_valid});
    end
    tick(2);
    init = 1'b0;
    tick(12);
    start_lookup(4'h5, 1'b0, 0, 0, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int c;
    for (int i = 0; i < DEPTH; i++) wr(i, 4'hF);
    check_any("b2b_any", 1'b1);
    c = cyc;
    ifc.lk_start = 1'b1; ifc.lk_key = 4'hF;
    push_exp(1'b1, 0, 7, 8, c + 9);
    push_exp(1'b1, 0, 7, 8, c + 18);
    tick(10);
    ifc.lk_start = 1'b0;
    wait_drain();
  endtask

  initial begin
    ifc.wr_en = 1'b0; ifc.wr_idx = '0; ifc.wr_data = '0;
    ifc.clr_en = 1'b0; ifc.clr_idx = '0;
    ifc.lk_start = 1'b0; ifc.lk_key = '0;
    test_reset();
    test_basic();
    test_clear();
    test_wr_clr();
    test_midscan();
    test_reset_midscan();
    test_back_to_back();
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
